// File: rtl/imem_responder_pkg.sv
// Types and limits for the instruction-memory responder.
package imem_responder_pkg;
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } imem_state_t;

  localparam int unsigned IMEM_MAX_WAIT = 15;
  localparam int unsigned IMEM_CNT_W    = 4;
endpackage

// File: rtl/riscv_defines.sv
// Core-wide datapath widths shared by the fetch path and its memories.
package riscv_defines;
  localparam int unsigned RISCV_ADDR_WIDTH = 32;
  localparam int unsigned RISCV_WORD_WIDTH = 32;
endpackage

// File: rtl/sram_1rw_be.sv
// Synchronous single-port RAM, 4 byte lanes, read-before-write.
module sram_1rw_be #(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter string       INIT_FILE   = "",
  localparam int unsigned AW         = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_en,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  // The output register samples the word before this cycle's lane writes land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_rdata <= '0;
    else if (i_en) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/imem_responder.sv
// Memory side of the instruction fetch valid/ready port with programmable wait states.
module imem_responder
  import riscv_defines::*;
  import imem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WAIT_STATES = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        imem_valid_i,
  output logic                        imem_ready_o,
  input  logic [RISCV_ADDR_WIDTH-1:0] imem_addr_i,
  input  logic [RISCV_WORD_WIDTH-1:0] imem_wdata_i,
  input  logic [3:0]                  imem_we_i,
  output logic [RISCV_WORD_WIDTH-1:0] imem_rdata_o,
  output logic                        imem_err_o
);
  localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
  localparam int unsigned WA_W  = RISCV_ADDR_WIDTH - 2;
  localparam logic [IMEM_CNT_W-1:0] CNT_INIT = IMEM_CNT_W'(WAIT_STATES);

  imem_state_t           r_state;
  logic [IMEM_CNT_W-1:0] r_cnt;
  logic [WA_W-1:0]       r_addr_q;
  logic                  r_oor;

  logic [WA_W-1:0]  w_word;
  logic [IDX_W-1:0] w_idx;
  logic             w_oor;
  logic             w_hit;
  logic             w_accept;
  logic             w_ram_en;
  logic [3:0]       w_ram_we;
  logic [31:0]      w_ram_rdata;
  logic             w_unused;

  assign w_word   = imem_addr_i[RISCV_ADDR_WIDTH-1:2];
  assign w_idx    = imem_addr_i[IDX_W+1:2];
  assign w_unused = ^imem_addr_i[1:0];

  if (IDX_W + 2 < RISCV_ADDR_WIDTH) begin : g_range
    assign w_oor = |imem_addr_i[RISCV_ADDR_WIDTH-1:IDX_W+2];
  end else begin : g_full
    assign w_oor = 1'b0;
  end

  assign w_hit    = imem_valid_i & (w_word == r_addr_q);
  assign w_accept = (r_state == IDLE) & imem_valid_i;
  // Write data and lane enables go straight to the RAM in the accept cycle,
  // so only the address and range flag need holding for the response.
  assign w_ram_en = w_accept & ~w_oor;
  assign w_ram_we = w_ram_en ? imem_we_i : '0;

  sram_1rw_be #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .INIT_FILE   (INIT_FILE)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_addr  (w_idx),
    .i_wdata (imem_wdata_i),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_addr_q <= '0;
      r_oor    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (imem_valid_i) begin
            r_addr_q <= w_word;
            r_oor    <= w_oor;
            r_cnt    <= CNT_INIT;
            r_state  <= (WAIT_STATES > 0) ? WAIT : RESP;
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (!w_hit)              r_state <= IDLE;
          else if (r_cnt == 4'd1)  r_state <= RESP;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign imem_ready_o = (r_state == RESP) & w_hit;
  assign imem_err_o   = imem_ready_o & r_oor;
  assign imem_rdata_o = r_oor ? '0 : w_ram_rdata;
endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder: the memory side of the core's instruction-memory valid/ready interface, answering fetch-stage requests with word data after a programmable number of wait states. It holds the program image in an internal synchronous single-port RAM, supports byte-lane writes for loader/debug traffic, and aborts cleanly when the initiator withdraws a request on a branch redirect. It sits between the fetch stage and the on-chip program memory.

## Interface
- `DEPTH_WORDS`, 4096: RAM depth in 32-bit words; must be a power of two.
- `WAIT_STATES`, 0: extra cycles between acceptance and response, 0..15.
- `INIT_FILE`, "": hex image loaded by `$readmemh` at elaboration; empty means no load.
- `clk`  in  1: clock.
- `rst_n`  in  1: asynchronous reset, active low.
- `imem_valid_i`  in  1: request present; may drop at any cycle.
- `imem_ready_o`  out  1: one-cycle response strobe; `imem_rdata_o` is valid in this cycle.
- `imem_addr_i`  in  RISCV_ADDR_WIDTH: byte address; bits [1:0] are ignored.
- `imem_wdata_i`  in  RISCV_WORD_WIDTH: write data.
- `imem_we_i`  in  4: byte-lane write enables; 0 means read.
- `imem_rdata_o`  out  RISCV_WORD_WIDTH: read data.
- `imem_err_o`  out  1: asserted with `imem_ready_o` when the word index is at or above `DEPTH_WORDS`.

## Operation
- FSM states: IDLE, WAIT, RESP. The state is defined as an enum in the package.
- **IDLE**
  - When `imem_valid_i`=1, accept the request.
  - Latch `addr_q = imem_addr_i[..:2]`, `we_q`, and `wdata`.
  - Issue the RAM access in the same cycle. The RAM returns the pre-write word, so a write returns the old contents.
  - Writes to out-of-range addresses are dropped.
  - Load the wait counter with `WAIT_STATES`.
  - Next state is WAIT if `WAIT_STATES`>0, otherwise RESP.
- **WAIT**: decrement the counter; go to RESP when it reaches 1.
- **RESP**
  - `imem_ready_o = imem_valid_i & (imem_addr_i[..:2] == addr_q)`. This is combinational on the registered state.
  - Return to IDLE after this cycle in all cases.
- **Abort**
  - In WAIT or RESP, if `imem_valid_i`=0 or the word address differs from `addr_q`, go to IDLE with no ready.
  - A write already issued stays committed.
- In IDLE, `imem_ready_o`=0.
- `imem_rdata_o` holds the RAM output register.
  - It is 0 for out-of-range reads, with `imem_err_o`=1.
  - Outside ready cycles its value is don't-care, but it must be stable.
- Word index = `addr[$clog2(DEPTH_WORDS)+1:2]`. Out-of-range means any higher address bit is set.

## Timing
- Reset values: state IDLE, `imem_ready_o`=0, `imem_err_o`=0, `imem_rdata_o`=0, counter 0, `addr_q`=0. RAM contents are not reset.
- Latency: with a request accepted at cycle N, ready occurs at cycle N+1+`WAIT_STATES`.
- Throughput:
  - One word every 2+`WAIT_STATES` cycles.
  - The cycle after a ready is always IDLE, because the initiator advances its address only at the end of the ready cycle.
  - A request still valid in that IDLE cycle is accepted immediately.
- Simultaneous abort and new request: an aborted request in RESP or WAIT needs one IDLE cycle before a redirected request is accepted. No request is ever answered with another address's data.
- Reset mid-operation: asynchronous return to IDLE; the response is lost. A RAM write in flight that cycle is undefined.
- Handshake: `imem_ready_o` never asserts while `imem_valid_i`=0.

## Structure
- Width constants `RISCV_ADDR_WIDTH` and `RISCV_WORD_WIDTH` come from `riscv_defines.sv`.
- Add to the package:
  - `imem_state_t` (IDLE/WAIT/RESP);
  - `IMEM_MAX_WAIT` = 15.
- Sub-module `sram_1rw_be`: synchronous single-port RAM with a 4-lane byte write, read-before-write, and optional `INIT_FILE`. The FSM, counter, and range check live in the top module.

## Test plan
- Reset with `INIT_FILE` word 0 = 0x00000013, `WAIT_STATES`=0. Hold valid with addr 0x0 from cycle 0. Required: ready at cycle 1 with rdata 0x00000013 and err=0; ready low at cycle 2.
- Sequential fetch with `WAIT_STATES`=2, addresses 0x0, 0x4, 0x8 advanced on ready. Required: ready at cycles 3, 7, 11 with image words 0, 1, 2.
- Abort: `WAIT_STATES`=3, drop valid at cycle 2 after acceptance, then present 0x40. Required: no ready for 0x0; ready for 0x40 with word 16, four cycles after its acceptance.
- Byte write: we=4'b0010, wdata=0xAABBCCDD to 0x8 holding 0x11223344. Required: the response returns 0x11223344; a following read of 0x8 returns 0x1122CC44.
- Out of range with `DEPTH_WORDS`=4096: read 0x4000. Required: ready with rdata=0 and err=1.
- Redirect in RESP: address changes from 0x10 to 0x80 in the RESP cycle. Required: no ready that cycle; 0x80 is accepted the next cycle and answered with word 32.
